// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the decoder handshake, the redirect request and the
//               program-load port of the instruction fetch unit.
//               master : decoder / loader side (drives requests, reads instr)
//               slave  : fetch unit side
// Ports       : fetch_en, next_instr, redirect_valid, redirect_pc,
//               prog_we, prog_addr, prog_wdata        (master -> slave)
//               instr, instr_pc, instr_valid, end_of_prog (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              fetch_en;
  logic              next_instr;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;
  logic              end_of_prog;

  modport master (
    output fetch_en, next_instr, redirect_valid, redirect_pc,
           prog_we, prog_addr, prog_wdata,
    input  instr, instr_pc, instr_valid, end_of_prog
  );

  modport slave (
    input  fetch_en, next_instr, redirect_valid, redirect_pc,
           prog_we, prog_addr, prog_wdata,
    output instr, instr_pc, instr_valid, end_of_prog
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program memory + PC + 2-entry prefetch buffer feeding the
//               decoder at up to one instruction per cycle, with PC redirect.
// Ports       : clk   - clock, all state updates on the rising edge
//               reset - synchronous, active-high
//               bus   - instr_fetch_unit_if.slave (handshake, redirect,
//                       program-load port, end_of_prog status)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int          MEM_DEPTH = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  instr_fetch_unit_if.slave  bus
);

  localparam logic [31:0] C_END_PC = 32'(MEM_DEPTH * 4);

  // Program memory: one sync write port, one sync read port.
  logic [31:0] prog_mem [MEM_DEPTH];
  logic [31:0] rdata_q;

  // Fetch state
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_tail;
  logic [2:0]  w_occ;
  logic        w_unused;

  // Redirect targets are forced word aligned, so the low bits are dropped.
  assign w_unused = ^bus.redirect_pc[1:0];

  assign w_valid = (count_q != 2'd0);
  assign w_pop   = bus.next_instr & w_valid & ~bus.redirect_valid;
  // A redirect in the completion cycle squashes the in-flight word.
  assign w_push  = inflight_q & ~bus.redirect_valid;
  assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q};
  // Issue only if the word will still have a slot when it lands next cycle;
  // a pop this cycle frees one, so issue resumes in the same cycle as a pop.
  assign w_issue = bus.fetch_en & ~reset & ~bus.redirect_valid &
                   (pc_q < C_END_PC) & (w_occ < (3'd2 + {2'b00, w_pop}));
  // Tail slot is head + count (mod 2); with count==2 a push only happens
  // together with a pop, so the overwritten slot is the departing head.
  assign w_tail  = head_q ^ count_q[0];

  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      prog_mem[bus.prog_addr] <= bus.prog_wdata;
    end
    if (w_issue) begin
      rdata_q <= prog_mem[pc_q[ADDR_W+1:2]];
    end
  end

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    head_d        = head_q;
    inflight_d    = w_issue;
    inflight_pc_d = inflight_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;

    if (bus.redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (w_push) begin
        fifo_instr_d[w_tail] = rdata_q;
        fifo_pc_d[w_tail]    = inflight_pc_q;
      end
      if (w_pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    if (w_issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload registers carry no reset; they are qualified by count/inflight.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    fifo_instr_q  <= fifo_instr_d;
    fifo_pc_q     <= fifo_pc_d;
  end

  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? fifo_instr_q[head_q] : 32'h0;
  assign bus.instr_pc    = w_valid ? fifo_pc_q[head_q]    : 32'h0;
  // ">=" also covers redirects past the end of memory.
  assign bus.end_of_prog = (pc_q >= C_END_PC) & ~w_valid & ~inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit using an
//               8-word program (word k = 32'h1000_0000 + k).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int C_DEPTH  = 8;
  localparam int C_ADDR_W = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  instr_fetch_unit_if #(.ADDR_W(C_ADDR_W)) bus ();

  instr_fetch_unit #(
    .MEM_DEPTH (C_DEPTH),
    .ADDR_W    (C_ADDR_W),
    .RESET_PC  (32'h0000_0000)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Head of buffer must be program word k.
  task automatic chk_word(input string tag, input int k);
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h1);
    chk({tag, "_instr"}, bus.instr, 32'h1000_0000 + 32'(k));
    chk({tag, "_pc"}, bus.instr_pc, 32'(k * 4));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset              = 1'b1;
    bus.fetch_en       = 1'b0;
    bus.next_instr     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.prog_we        = 1'b0;
    bus.prog_addr      = '0;
    bus.prog_wdata     = 32'h0;
    step();
    step();

    chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_eop", {31'h0, bus.end_of_prog}, 32'h0);

    // Load program with fetch disabled.
    reset = 1'b0;
    for (int i = 0; i < C_DEPTH; i++) begin
      bus.prog_we    = 1'b1;
      bus.prog_addr  = i[C_ADDR_W-1:0];
      bus.prog_wdata = 32'h1000_0000 + 32'(i);
      step();
    end
    bus.prog_we = 1'b0;
    step();
    chk("load_idle_valid", {31'h0, bus.instr_valid}, 32'h0);

    // Streaming run to the end of memory.
    bus.fetch_en   = 1'b1;
    bus.next_instr = 1'b1;
    step();
    chk("t1_lat1_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    for (int k = 0; k < C_DEPTH; k++) begin
      chk_word("t1_stream", k);
      step();
    end
    chk("end_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("end_eop", {31'h0, bus.end_of_prog}, 32'h1);
    step();
    chk("end_eop_hold", {31'h0, bus.end_of_prog}, 32'h1);

    // Redirect to 0 clears end_of_prog and refetches word 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    chk("eop_clr_eop", {31'h0, bus.end_of_prog}, 32'h0);
    chk("eop_clr_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk("eop_rf_lat1", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk_word("eop_refetch", 0);
    step();
    chk_word("eop_refetch", 1);

    // Mid-stream reset, then restart under backpressure.
    reset = 1'b1;
    step();
    chk("mrst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("mrst_instr", bus.instr, 32'h0);
    chk("mrst_pc", bus.instr_pc, 32'h0);
    chk("mrst_eop", {31'h0, bus.end_of_prog}, 32'h0);
    reset          = 1'b0;
    bus.next_instr = 1'b0;
    step();
    chk("mrst_lat1", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk_word("mrst_first", 0);
    step();
    step();
    step();
    chk_word("bp_hold", 0);
    bus.next_instr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_word("bp_resume", k);
      step();
    end

    // Redirect to an unaligned PC while a word is buffered and one in flight.
    bus.next_instr     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    chk_word("t3_pre", 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0013;
    step();
    bus.redirect_valid = 1'b0;
    bus.next_instr     = 1'b1;
    chk("t3_flush_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk("t3_lat1_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk_word("t3_tgt", 4);
    step();
    chk_word("t3_tgt", 5);
    step();
    chk_word("t3_tgt", 6);

    // Redirect and pop in the same cycle: redirect wins.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0008;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_flush_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk("t4_lat1_valid", {31'h0, bus.instr_valid}, 32'h0);
    step();
    chk_word("t4_tgt", 2);
    step();
    chk_word("t4_tgt", 3);

    // Redirect past the end of memory: no fetch, end_of_prog.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("t5_eop", {31'h0, bus.end_of_prog}, 32'h1);
    step();
    step();
    chk("t5_valid_hold", {31'h0, bus.instr_valid}, 32'h0);
    chk("t5_eop_hold", {31'h0, bus.end_of_prog}, 32'h1);

    // Redirect to the last word: one instruction then end_of_prog.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_001C;
    step();
    bus.redirect_valid = 1'b0;
    chk("t6_eop_clr", {31'h0, bus.end_of_prog}, 32'h0);
    step();
    step();
    chk_word("t6_last", 7);
    step();
    chk("t6_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("t6_eop", {31'h0, bus.end_of_prog}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
